uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one uart_tx byte channel among NUM_REQ independent byte requesters, e.g. the CPU TX register, a hardware debug monitor, and a boot loader echo path.
- Sits between the requesters and the uart_tx instance.
- Arbitrates round-robin, one byte per grant, and drives the uart_tx valid/ready handshake.
- Reports the current owner so software and debug logic can observe contention.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..4.
- IDW, 2, width of grant_id; must satisfy 2**IDW >= NUM_REQ.
- LOCK_TIMEOUT, 65535, idle cycles after which a held line-lock is released. Used only with the optional feature.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- req_valid, input, NUM_REQ: bit i set = requester i has a byte pending.
- req_data, input, 8*NUM_REQ: byte of requester i on bits [8i+7:8i].
- req_ready, output, NUM_REQ: one-cycle pulse; byte of requester i captured.
- tx_data, output, 8: byte to uart_tx.
- tx_data_valid, output, 1: byte presented to uart_tx.
- tx_data_ready, input, 1: uart_tx able to accept.
- grant_id, output, IDW: index of the last or current owner.
- busy, output, 1: a byte is held waiting for uart_tx.

Behaviour:
- Reset values: tx_data=0x00, tx_data_valid=0, req_ready=0, grant_id=0, busy=0, round-robin pointer=0, FSM=IDLE. Reset takes effect immediately, including mid-transfer; any held byte is discarded.
- FSM states: IDLE, SEND, GAP.
- IDLE:
  - If any req_valid is set, pick the first set bit searching from ptr upward, with wrap-around modulo NUM_REQ.
  - Next cycle: tx_data <= that byte, tx_data_valid <= 1, busy <= 1, req_ready[i] pulses for exactly that one cycle, grant_id <= i, ptr <= (i+1) mod NUM_REQ.
  - Go to SEND.
  - Latency from req_valid to tx_data_valid is 1 cycle.
- SEND:
  - Hold tx_data and tx_data_valid=1 until a cycle with tx_data_valid && tx_data_ready.
  - Next cycle: tx_data_valid <= 0, busy <= 0, go to GAP.
- GAP:
  - One mandatory idle cycle, so uart_tx sees valid low between bytes.
  - Then return to IDLE.
  - Minimum byte period is 3 cycles: grant, accept, gap.
- Requester rule: hold req_valid and req_data stable until req_ready. The arbiter samples req_valid only in IDLE. A request dropped before its grant is simply not served; no error is flagged.
- Simultaneous requests: strict round-robin. A requester served once cannot be served again while any other requester has a request pending.
- req_valid rising in SEND or GAP is queued implicitly and evaluated in the next IDLE.
- If tx_data_ready is already high in the first SEND cycle, the transfer completes that cycle. No timeout on tx_data_ready.
- At most one req_ready bit is set in any cycle.

Optional Feature:
- Macro: UART_TX_ARB_LINE_LOCK_EN.
- With the macro defined:
  - After granting requester i, the arbiter locks to i. In IDLE only req_valid[i] is considered.
  - The lock is released after a byte equal to 0x0A is accepted by uart_tx.
  - The lock is also released after LOCK_TIMEOUT consecutive IDLE cycles with req_valid[i]=0. A 16-bit saturating counter cleared on each grant to i provides this.
  - On release, the pointer advances as normal.
  - Net effect: text lines from different requesters never interleave.
- Without the macro: pure per-byte round-robin. The lock logic and counter are absent.

Decomposition:
- Package uart_arb_pkg:
  - FSM state enum (IDLE, SEND, GAP).
  - NUM_REQ_MAX=4.
  - ASCII_LF=8'h0A.
  - Default LOCK_TIMEOUT.
- Sub-module uart_rr_pick: combinational rotate-priority picker.
  - Inputs: req vector, ptr, and a lock mask.
  - Outputs: grant one-hot, index, any.
  - Reused by the planned UART B arbiter.

Test Plan:
- Single request: req_valid=2'b01, data 0x41, tx_data_ready=1 → req_ready[0] pulses the cycle after; tx_data=0x41 with valid for 1 cycle; GAP; grant_id=0.
- Contention: both requesters valid continuously, data 0x11 and 0x22, ready=1 → output sequence 0x11, 0x22, 0x11, 0x22; each byte 3 cycles apart.
- Backpressure: tx_data_ready=0 for 50 cycles then 1 → tx_data_valid and tx_data held stable all 50 cycles; busy=1; no extra req_ready pulses.
- Reset mid-SEND: assert rst_n=0 with valid=1 → tx_data_valid=0 and busy=0 immediately; after release, ptr=0 and requester 0 wins a tie.
- NUM_REQ=3 wrap: after a grant to 2, all three requesting → grant order is 0, then 1, then 2.
- With UART_TX_ARB_LINE_LOCK_EN:
  - Req0 sends 'A', 'B', 0x0A while req1 is valid → req1's first byte appears only after 0x0A.
  - Separately, req0 idle for LOCK_TIMEOUT cycles → req1 is granted.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART TX byte-channel arbiters.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StSend = 2'd1,
        StGap  = 2'd2
    } arb_state_e;

    localparam int unsigned NUM_REQ_MAX      = 4;
    localparam logic [7:0]  ASCII_LF         = 8'h0A;
    localparam int unsigned LOCK_TIMEOUT_DEF = 65535;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational rotate-priority picker: first masked request at or above ptr, wrapping modulo N.
module uart_rr_pick
    import uart_arb_pkg::*;
#(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic [N-1:0]  mask,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [N-1:0] req_m;
    int unsigned  j;

    assign req_m = req & mask;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int unsigned k = 0; k < N; k++) begin
            j = 32'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!any && req_m[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx byte channel among NUM_REQ requesters.
// Optional line locking (no interleaving of text lines) with UART_TX_ARB_LINE_LOCK_EN.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 2,
    parameter int unsigned IDW          = 2,
    parameter int unsigned LOCK_TIMEOUT = LOCK_TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_data_valid,
    input  logic                 tx_data_ready,
    output logic [IDW-1:0]       grant_id,
    output logic                 busy
);

    arb_state_e         state_q, state_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_valid_q, tx_valid_d;
    logic [NUM_REQ-1:0] ready_q, ready_d;
    logic [IDW-1:0]     gid_q, gid_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic               busy_q, busy_d;

    logic [NUM_REQ-1:0] lock_mask;
    logic [NUM_REQ-1:0] pick_gnt;
    logic [IDW-1:0]     pick_idx;
    logic               pick_any;
    logic [IDW-1:0]     ptr_nxt;
    logic               tx_accept;

    uart_rr_pick #(
        .N  (NUM_REQ),
        .IW (IDW)
    ) u_pick (
        .req  (req_valid),
        .ptr  (ptr_q),
        .mask (lock_mask),
        .gnt  (pick_gnt),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    assign ptr_nxt   = (32'(pick_idx) == NUM_REQ - 1) ? '0 : pick_idx + 1'b1;
    assign tx_accept = (state_q == StSend) && tx_valid_q && tx_data_ready;

`ifdef UART_TX_ARB_LINE_LOCK_EN
    logic        lock_q, lock_d;
    logic [15:0] idle_cnt_q, idle_cnt_d;
    logic [15:0] idle_cnt_inc;

    // While locked, the owner is the last granted requester (gid_q).
    assign lock_mask    = lock_q ? (NUM_REQ'(1) << gid_q) : '1;
    assign idle_cnt_inc = (idle_cnt_q == 16'hFFFF) ? idle_cnt_q : idle_cnt_q + 16'd1;

    always_comb begin
        lock_d     = lock_q;
        idle_cnt_d = idle_cnt_q;
        if (state_q == StIdle && pick_any) begin
            lock_d     = 1'b1;
            idle_cnt_d = '0;
        end else if (state_q == StIdle && lock_q && !req_valid[gid_q]) begin
            idle_cnt_d = idle_cnt_inc;
            if (32'(idle_cnt_inc) >= LOCK_TIMEOUT) begin
                lock_d = 1'b0;
            end
        end
        if (tx_accept && tx_data_q == ASCII_LF) begin
            lock_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q     <= 1'b0;
            idle_cnt_q <= '0;
        end else begin
            lock_q     <= lock_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end
`else
    assign lock_mask = '1;
`endif

    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        ready_d    = '0;
        gid_d      = gid_q;
        ptr_d      = ptr_q;
        busy_d     = busy_q;
        unique case (state_q)
            StIdle: begin
                if (pick_any) begin
                    tx_data_d  = req_data[8*pick_idx +: 8];
                    tx_valid_d = 1'b1;
                    busy_d     = 1'b1;
                    ready_d    = pick_gnt;
                    gid_d      = pick_idx;
                    ptr_d      = ptr_nxt;
                    state_d    = StSend;
                end
            end
            StSend: begin
                if (tx_accept) begin
                    tx_valid_d = 1'b0;
                    busy_d     = 1'b0;
                    state_d    = StGap;
                end
            end
            StGap: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            ready_q    <= '0;
            gid_q      <= '0;
            ptr_q      <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            ready_q    <= ready_d;
            gid_q      <= gid_d;
            ptr_q      <= ptr_d;
            busy_q     <= busy_d;
        end
    end

    assign tx_data       = tx_data_q;
    assign tx_data_valid = tx_valid_q;
    assign req_ready     = ready_q;
    assign grant_id      = gid_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter; line-lock scenarios run when UART_TX_ARB_LINE_LOCK_EN is set.
module tb_uart_tx_arbiter;

    localparam int unsigned NREQ    = 3;
    localparam int unsigned IDW     = 2;
    localparam int unsigned LOCK_TO = 20;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] id;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic [7:0]        tx_data;
    logic              tx_data_valid;
    logic              tx_data_ready;
    logic [IDW-1:0]    grant_id;
    logic              busy;

    logic [7:0] rq [NREQ][$];
    exp_t       exp_q[$];
    logic       rdy_en = 1'b1;
    logic       chk_period = 1'b0;
    int         n_checks = 0;
    int         n_pass = 0;
    int         cyc = 0;
    int         last_acc = -1;
    int         acc_cnt = 0;

    uart_tx_arbiter #(
        .NUM_REQ      (NREQ),
        .IDW          (IDW),
        .LOCK_TIMEOUT (LOCK_TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .tx_data       (tx_data),
        .tx_data_valid (tx_data_valid),
        .tx_data_ready (tx_data_ready),
        .grant_id      (grant_id),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    function automatic exp_t mk(input logic [7:0] d, input logic [1:0] id);
        exp_t r;
        r.data = d;
        r.id   = id;
        return r;
    endfunction

    function automatic bit rq_pending();
        for (int i = 0; i < NREQ; i++) if (rq[i].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    // Requesters: hold byte until req_ready, then present the next one. All DUT inputs change here.
    initial begin
        req_valid     = '0;
        req_data      = '0;
        tx_data_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i] && rq[i].size() != 0) void'(rq[i].pop_front());
                if (rq[i].size() != 0) begin
                    req_valid[i]        = 1'b1;
                    req_data[8*i +: 8]  = rq[i][0];
                end else begin
                    req_valid[i]        = 1'b0;
                    req_data[8*i +: 8]  = 8'h00;
                end
            end
            tx_data_ready = rdy_en;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (req_ready != '0) begin
                check_eq("rdy_onehot", 32'(req_ready), 32'(1) << grant_id);
                check_eq("rdy_with_valid", 32'(tx_data_valid), 32'd1);
            end
            if (tx_data_valid && tx_data_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("byte_expected", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("tx_data", 32'(tx_data), 32'(e.data));
                    check_eq("grant_id", 32'(grant_id), 32'(e.id));
                end
                if (chk_period && last_acc >= 0) check_eq("byte_period", 32'(cyc - last_acc), 32'd3);
                last_acc = cyc;
                acc_cnt++;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_drain(input int max_cyc);
        int n = 0;
        while ((exp_q.size() != 0 || busy || tx_data_valid || rq_pending()) && n < max_cyc) begin
            step();
            n++;
        end
        check_eq("drain_in_time", 32'(n < max_cyc), 32'd1);
        repeat (2) step();
    endtask

    task automatic wait_valid(input int max_cyc);
        int n = 0;
        while (!tx_data_valid && n < max_cyc) begin
            step();
            n++;
        end
        check_eq("valid_in_time", 32'(tx_data_valid), 32'd1);
    endtask

    task automatic wait_acc(input int max_cyc);
        int n = 0;
        int start = acc_cnt;
        while (acc_cnt == start && n < max_cyc) begin
            step();
            n++;
        end
        check_eq("accept_in_time", 32'(acc_cnt != start), 32'd1);
    endtask

    initial begin
        int a0;
        int d;
        rst_n = 1'b0;
        repeat (3) step();
        check_eq("rst_tx_data", 32'(tx_data), 32'h00);
        check_eq("rst_valid", 32'(tx_data_valid), 32'd0);
        check_eq("rst_ready", 32'(req_ready), 32'd0);
        check_eq("rst_grant_id", 32'(grant_id), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        step();

        // Single request: one-cycle latency, one-cycle valid, then gap.
        rq[0].push_back(8'h41);
        exp_q.push_back(mk(8'h41, 2'd0));
        step();
        check_eq("single_req_up", 32'(req_valid[0]), 32'd1);
        check_eq("single_pre_valid", 32'(tx_data_valid), 32'd0);
        step();
        check_eq("single_valid", 32'(tx_data_valid), 32'd1);
        check_eq("single_ready", 32'(req_ready), 32'b001);
        check_eq("single_data", 32'(tx_data), 32'h41);
        check_eq("single_busy", 32'(busy), 32'd1);
        step();
        check_eq("gap_valid", 32'(tx_data_valid), 32'd0);
        check_eq("gap_busy", 32'(busy), 32'd0);
        check_eq("gap_grant_id", 32'(grant_id), 32'd0);
        check_eq("gap_ready", 32'(req_ready), 32'd0);
        step();
        check_eq("idle_valid", 32'(tx_data_valid), 32'd0);
        wait_drain(20);

`ifdef UART_TX_ARB_LINE_LOCK_EN
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        step();

        // Requester 0 owns the line until its LF is accepted.
        rq[0].push_back(8'h41);
        rq[0].push_back(8'h42);
        rq[0].push_back(8'h0A);
        rq[1].push_back(8'h31);
        exp_q.push_back(mk(8'h41, 2'd0));
        exp_q.push_back(mk(8'h42, 2'd0));
        exp_q.push_back(mk(8'h0A, 2'd0));
        exp_q.push_back(mk(8'h31, 2'd1));
        wait_drain(100);

        // Lock held by 1; requester 0 only gets in after the idle timeout.
        rq[0].push_back(8'h55);
        exp_q.push_back(mk(8'h55, 2'd0));
        wait_acc(10 * LOCK_TO);
        a0 = last_acc;
        rq[1].push_back(8'h56);
        exp_q.push_back(mk(8'h56, 2'd1));
        wait_acc(10 * LOCK_TO);
        d = last_acc - a0;
        check_eq("lock_timeout_wait", 32'(d >= LOCK_TO + 2 && d <= LOCK_TO + 4), 32'd1);
        wait_drain(50);
`else
        // Requester 1 alone moves the pointer to 2 so contention starts at requester 0.
        rq[1].push_back(8'h33);
        exp_q.push_back(mk(8'h33, 2'd1));
        wait_drain(20);

        last_acc   = -1;
        chk_period = 1'b1;
        rq[0].push_back(8'h11);
        rq[0].push_back(8'h11);
        rq[1].push_back(8'h22);
        rq[1].push_back(8'h22);
        exp_q.push_back(mk(8'h11, 2'd0));
        exp_q.push_back(mk(8'h22, 2'd1));
        exp_q.push_back(mk(8'h11, 2'd0));
        exp_q.push_back(mk(8'h22, 2'd1));
        wait_drain(100);
        chk_period = 1'b0;

        // Backpressure: byte held stable, no extra grants while stalled.
        rdy_en = 1'b0;
        step();
        rq[2].push_back(8'h5A);
        exp_q.push_back(mk(8'h5A, 2'd2));
        wait_valid(10);
        for (int i = 0; i < 50; i++) begin
            check_eq("bp_valid", 32'(tx_data_valid), 32'd1);
            check_eq("bp_data", 32'(tx_data), 32'h5A);
            check_eq("bp_busy", 32'(busy), 32'd1);
            check_eq("bp_ready", 32'(req_ready), (i == 0) ? 32'b100 : 32'd0);
            if (i == 10) begin
                rq[0].push_back(8'h66);
                exp_q.push_back(mk(8'h66, 2'd0));
            end
            step();
        end
        rdy_en = 1'b1;
        wait_drain(30);

        // Reset mid-SEND discards the held byte and restores the pointer.
        rdy_en = 1'b0;
        step();
        rq[1].push_back(8'h77);
        wait_valid(10);
        step();
        check_eq("rst_req_drop", 32'(req_valid[1]), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", 32'(tx_data_valid), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_data", 32'(tx_data), 32'h00);
        check_eq("mid_rst_grant", 32'(grant_id), 32'd0);
        rdy_en = 1'b1;
        rq[0].push_back(8'h01);
        rq[1].push_back(8'h02);
        exp_q.push_back(mk(8'h01, 2'd0));
        exp_q.push_back(mk(8'h02, 2'd1));
        repeat (3) step();
        rst_n = 1'b1;
        wait_drain(30);

        // Wrap: after a grant to 2, a full tie is served 0, 1, 2.
        rq[2].push_back(8'h30);
        exp_q.push_back(mk(8'h30, 2'd2));
        wait_drain(20);
        rq[0].push_back(8'h40);
        rq[1].push_back(8'h41);
        rq[2].push_back(8'h42);
        exp_q.push_back(mk(8'h40, 2'd0));
        exp_q.push_back(mk(8'h41, 2'd1));
        exp_q.push_back(mk(8'h42, 2'd2));
        wait_drain(40);
`endif

        check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
